// File: rtl/iiitb_wm_plant.sv
// iiitb_wm_plant
// Cycle-based plant and sensor model for the washing machine controller.
// It takes the controller's actuator outputs and returns the sensor and
// timeout inputs the controller expects. It also latches the first unsafe
// actuator combination it sees.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   door_lock             door locked by controller
//   motor_on              drum motor running
//   fill_value_on         inlet valve open
//   drain_value_on        drain valve open
//   soap_wash, water_wash wash / rinse phase flags
//   done                  controller cycle complete (clears timers)
//   filled, drained       registered level == LEVEL_MAX / level == 0
//   detergent_added       sticky until done
//   cycle_timeout         agitation time elapsed
//   spin_timeout          spin time elapsed, sticky until done
//   water_level           current level, in fill steps
//   fault, fault_code     sticky fault flag and first cause
//                         (0 none, 1 door, 2 valve conflict, 3 overflow)
module iiitb_wm_plant #(
  parameter int LW          = 4,
  parameter int LEVEL_MAX   = 8,
  parameter int DET_CYCLES  = 3,
  parameter int WASH_CYCLES = 10,
  parameter int SPIN_CYCLES = 6,
  parameter int OVF_LIMIT   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          door_lock,
  input  logic          motor_on,
  input  logic          fill_value_on,
  input  logic          drain_value_on,
  input  logic          soap_wash,
  input  logic          water_wash,
  input  logic          done,
  output logic          filled,
  output logic          drained,
  output logic          detergent_added,
  output logic          cycle_timeout,
  output logic          spin_timeout,
  output logic [LW-1:0] water_level,
  output logic          fault,
  output logic [1:0]    fault_code
);

  localparam int DCW = $clog2(DET_CYCLES + 1);
  localparam int WCW = $clog2(WASH_CYCLES + 1);
  localparam int SCW = $clog2(SPIN_CYCLES + 1);
  localparam int OCW = $clog2(OVF_LIMIT + 1);

  logic [LW-1:0]  level_nxt;
  logic [DCW-1:0] det_cnt, det_cnt_nxt;
  logic [WCW-1:0] wash_cnt, wash_cnt_nxt;
  logic [SCW-1:0] spin_cnt, spin_cnt_nxt;
  logic [OCW-1:0] ovf_cnt, ovf_cnt_nxt;
  logic           soap_q, water_q;
  logic           det_run, wash_run, spin_run, ovf_run, phase_chg;
  logic [1:0]     fault_cause;

  // Level: fill and drain together cancel out; both ends saturate.
  always_comb begin
    level_nxt = water_level;
    if (fill_value_on && !drain_value_on) begin
      if (water_level != LW'(LEVEL_MAX)) level_nxt = water_level + LW'(1);
    end else if (drain_value_on && !fill_value_on) begin
      if (water_level != '0) level_nxt = water_level - LW'(1);
    end
  end

  // Counter run conditions use the registered filled/drained flags, i.e. the
  // sensor state the controller is currently seeing.
  always_comb begin
    det_run   = soap_wash && filled && !drain_value_on;
    wash_run  = motor_on && filled && !drain_value_on && (soap_wash ^ water_wash);
    phase_chg = (soap_wash != soap_q) || (water_wash != water_q);
    spin_run  = motor_on && drain_value_on && drained;
    ovf_run   = fill_value_on && filled;
  end

  // Saturating counters; done clears the three process timers but not the
  // overflow watchdog, which belongs to fault detection.
  always_comb begin
    det_cnt_nxt = '0;
    if (!done && det_run)
      det_cnt_nxt = (det_cnt == DCW'(DET_CYCLES)) ? det_cnt : det_cnt + DCW'(1);

    wash_cnt_nxt = '0;
    if (!done && wash_run && !phase_chg)
      wash_cnt_nxt = (wash_cnt == WCW'(WASH_CYCLES)) ? wash_cnt : wash_cnt + WCW'(1);

    spin_cnt_nxt = '0;
    if (!done && spin_run)
      spin_cnt_nxt = (spin_cnt == SCW'(SPIN_CYCLES)) ? spin_cnt : spin_cnt + SCW'(1);

    ovf_cnt_nxt = '0;
    if (ovf_run)
      ovf_cnt_nxt = (ovf_cnt == OCW'(OVF_LIMIT)) ? ovf_cnt : ovf_cnt + OCW'(1);
  end

  // Highest-priority fault cause present this cycle.
  always_comb begin
    fault_cause = 2'd0;
    if ((motor_on || fill_value_on) && !door_lock)
      fault_cause = 2'd1;
    else if (fill_value_on && drain_value_on)
      fault_cause = 2'd2;
    else if (ovf_cnt_nxt == OCW'(OVF_LIMIT))
      fault_cause = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      water_level     <= '0;
      filled          <= 1'b0;
      drained         <= 1'b0;
      det_cnt         <= '0;
      wash_cnt        <= '0;
      spin_cnt        <= '0;
      ovf_cnt         <= '0;
      soap_q          <= 1'b0;
      water_q         <= 1'b0;
      detergent_added <= 1'b0;
      cycle_timeout   <= 1'b0;
      spin_timeout    <= 1'b0;
      fault           <= 1'b0;
      fault_code      <= 2'd0;
    end else begin
      water_level <= level_nxt;
      filled      <= (level_nxt == LW'(LEVEL_MAX));
      drained     <= (level_nxt == '0);
      det_cnt     <= det_cnt_nxt;
      wash_cnt    <= wash_cnt_nxt;
      spin_cnt    <= spin_cnt_nxt;
      ovf_cnt     <= ovf_cnt_nxt;
      soap_q      <= soap_wash;
      water_q     <= water_wash;

      detergent_added <= !done && (detergent_added || (det_cnt_nxt == DCW'(DET_CYCLES)));
      spin_timeout    <= !done && (spin_timeout || (spin_cnt_nxt == SCW'(SPIN_CYCLES)));

      if (done || drain_value_on)
        cycle_timeout <= 1'b0;
      else if (wash_cnt_nxt == WCW'(WASH_CYCLES))
        cycle_timeout <= 1'b1;

      if (!fault && fault_cause != 2'd0) begin
        fault      <= 1'b1;
        fault_code <= fault_cause;
      end
    end
  end

endmodule

// File: tb/tb_iiitb_wm_plant.sv
// Self-checking bench for iiitb_wm_plant: directed scenarios followed by
// random actuator traffic, every cycle compared against a behavioural model.
module tb_iiitb_wm_plant;

  localparam int LW = 4, LEVEL_MAX = 8, DET_CYCLES = 3, WASH_CYCLES = 10;
  localparam int SPIN_CYCLES = 6, OVF_LIMIT = 4;

  logic clk = 1'b0;
  logic reset, door_lock, motor_on, fill_value_on, drain_value_on;
  logic soap_wash, water_wash, done;
  logic filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;
  logic [LW-1:0] water_level;
  logic [1:0] fault_code;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state (plain integers).
  int m_level, m_filled, m_drained, m_det_added, m_cto, m_sto, m_fault, m_code;
  int t_det, t_wash, t_spin, t_ovf;
  int last_soap, last_water;

  iiitb_wm_plant dut (
    .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .filled(filled), .drained(drained), .detergent_added(detergent_added),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
    .water_level(water_level), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply the behavioural rules for one rising edge using the current inputs.
  task automatic model_edge();
    int cause, new_level;
    if (reset) begin
      m_level = 0; m_filled = 0; m_drained = 0; m_det_added = 0; m_cto = 0;
      m_sto = 0; m_fault = 0; m_code = 0;
      t_det = 0; t_wash = 0; t_spin = 0; t_ovf = 0;
      last_soap = 0; last_water = 0;
      return;
    end
    new_level = imax(0, imin(LEVEL_MAX,
                m_level + int'(fill_value_on && !drain_value_on)
                        - int'(drain_value_on && !fill_value_on)));

    // Time spent in each condition, capped at its terminal value.
    t_det = (!done && soap_wash && m_filled == 1 && !drain_value_on)
            ? imin(t_det + 1, DET_CYCLES) : 0;
    t_wash = (!done && motor_on && m_filled == 1 && !drain_value_on &&
              (soap_wash != water_wash) &&
              int'(soap_wash) == last_soap && int'(water_wash) == last_water)
             ? imin(t_wash + 1, WASH_CYCLES) : 0;
    t_spin = (!done && motor_on && drain_value_on && m_drained == 1)
             ? imin(t_spin + 1, SPIN_CYCLES) : 0;
    t_ovf = (fill_value_on && m_filled == 1) ? imin(t_ovf + 1, OVF_LIMIT) : 0;

    m_det_added = (!done && (m_det_added == 1 || t_det == DET_CYCLES)) ? 1 : 0;
    m_sto       = (!done && (m_sto == 1 || t_spin == SPIN_CYCLES)) ? 1 : 0;
    if (done || drain_value_on) m_cto = 0;
    else if (t_wash == WASH_CYCLES) m_cto = 1;

    if ((motor_on || fill_value_on) && !door_lock) cause = 1;
    else if (fill_value_on && drain_value_on)      cause = 2;
    else if (t_ovf == OVF_LIMIT)                   cause = 3;
    else                                           cause = 0;
    if (m_fault == 0 && cause != 0) begin
      m_fault = 1;
      m_code  = cause;
    end

    m_level    = new_level;
    m_filled   = (new_level == LEVEL_MAX) ? 1 : 0;
    m_drained  = (new_level == 0) ? 1 : 0;
    last_soap  = int'(soap_wash);
    last_water = int'(water_wash);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("water_level", 32'(water_level), m_level);
    chk("filled", 32'(filled), m_filled);
    chk("drained", 32'(drained), m_drained);
    chk("detergent_added", 32'(detergent_added), m_det_added);
    chk("cycle_timeout", 32'(cycle_timeout), m_cto);
    chk("spin_timeout", 32'(spin_timeout), m_sto);
    chk("fault", 32'(fault), m_fault);
    chk("fault_code", 32'(fault_code), m_code);
  endtask

  task automatic set_in(input logic dl, input logic mo, input logic fi,
                        input logic dr, input logic so, input logic wa,
                        input logic dn);
    door_lock = dl; motor_on = mo; fill_value_on = fi; drain_value_on = dr;
    soap_wash = so; water_wash = wa; done = dn;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);

    // 1: reset, then release
    repeat (2) step();
    chk("rst_drained", 32'(drained), 0);
    chk("rst_fault", 32'(fault), 0);
    reset = 1'b0;
    step();
    chk("rel_drained", 32'(drained), 1);
    chk("rel_level", 32'(water_level), 0);

    // 2: fill from empty, then overflow
    set_in(1, 0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= LEVEL_MAX; i++) begin
      step();
      chk("fill_level", 32'(water_level), i);
      chk("fill_filled", 32'(filled), (i == LEVEL_MAX) ? 1 : 0);
      chk("fill_drained", 32'(drained), 0);
    end
    for (int i = 1; i <= OVF_LIMIT; i++) begin
      step();
      chk("ovf_fault", 32'(fault), (i == OVF_LIMIT) ? 1 : 0);
    end
    chk("ovf_code", 32'(fault_code), 3);

    // 3: detergent, agitation timeout, drain
    set_in(1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= DET_CYCLES; i++) begin
      step();
      chk("det_added", 32'(detergent_added), (i == DET_CYCLES) ? 1 : 0);
    end
    motor_on = 1'b1;
    for (int i = 1; i <= WASH_CYCLES; i++) begin
      step();
      chk("wash_to", 32'(cycle_timeout), (i == WASH_CYCLES) ? 1 : 0);
    end
    set_in(1, 0, 0, 1, 1, 0, 0);
    for (int i = 1; i <= LEVEL_MAX; i++) begin
      step();
      chk("drain_to", 32'(cycle_timeout), 0);
      chk("drain_level", 32'(water_level), LEVEL_MAX - i);
    end

    // 4: spin, then done
    set_in(1, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i <= SPIN_CYCLES; i++) begin
      step();
      chk("spin_to", 32'(spin_timeout), (i == SPIN_CYCLES) ? 1 : 0);
    end
    done = 1'b1;
    step();
    chk("done_det", 32'(detergent_added), 0);
    chk("done_spin", 32'(spin_timeout), 0);
    chk("done_fault_kept", 32'(fault), 1);
    done = 1'b0;

    // 5: phase toggle restarts the agitation timer
    set_in(1, 0, 1, 0, 1, 0, 0);
    repeat (LEVEL_MAX) step();
    fill_value_on = 1'b0;
    motor_on = 1'b1;
    for (int i = 1; i <= 7; i++) step();
    chk("pre_toggle_to", 32'(cycle_timeout), 0);
    soap_wash = 1'b0;
    water_wash = 1'b1;
    for (int i = 1; i <= WASH_CYCLES + 1; i++) begin
      step();
      chk("toggle_to", 32'(cycle_timeout), (i == WASH_CYCLES + 1) ? 1 : 0);
    end

    // 6: door fault wins and is retained over a later valve conflict
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    reset = 1'b0;
    set_in(1, 0, 1, 0, 0, 0, 0);
    repeat (3) step();
    set_in(0, 1, 0, 0, 0, 0, 0);
    step();
    chk("door_code", 32'(fault_code), 1);
    set_in(1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("conflict_code", 32'(fault_code), 1);
      chk("conflict_level", 32'(water_level), 3);
    end
    reset = 1'b1;
    step();
    chk("reset_fault", 32'(fault), 0);
    reset = 1'b0;

    // Random traffic
    set_in(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(0, 79) == 0);
      door_lock      = ($urandom_range(0, 31) != 0);
      motor_on       = ($urandom_range(0, 2) != 0);
      fill_value_on  = ($urandom_range(0, 2) == 0);
      drain_value_on = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) soap_wash  = ~soap_wash;
      if ($urandom_range(0, 7) == 0) water_wash = ~water_wash;
      done           = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
